// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of one shared line-wide memory port.
// Each grant is locked until the holder drops req, and one dead cycle separates owners.
module mem_arbiter #(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  localparam int DW             = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  req,
  input  logic [2:0]                  rd_en_in,
  input  logic [2:0]                  wr_en_in,
  input  logic [3*ADDR_SIZE_BITS-1:0] addr_in,
  input  logic [3*DW-1:0]             wdata_in,
  output logic [2:0]                  gnt,
  output logic [DW-1:0]               read_data_out,
  output logic                        mem_read_enable,
  output logic                        mem_write_enable,
  output logic [ADDR_SIZE_BITS-1:0]   mem_address,
  output logic [DW-1:0]               mem_write_data,
  input  logic [DW-1:0]               mem_read_data,
  output logic                        protocol_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [1:0]                last_q, last_d;
  logic [2:0]                gnt_q, gnt_d;
  logic [1:0]                pick_s;
  logic                      hold_req_s, hold_rd_s, hold_wr_s;
  logic [ADDR_SIZE_BITS-1:0] hold_addr_s;
  logic [DW-1:0]             hold_wdata_s;
  logic                      conflict_s;

  // Round-robin search order starts just after the last winner and wraps.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] a0, a1, a2;
    case (last)
      2'd0:    begin a0 = 2'd1; a1 = 2'd2; a2 = 2'd0; end
      2'd1:    begin a0 = 2'd2; a1 = 2'd0; a2 = 2'd1; end
      default: begin a0 = 2'd0; a1 = 2'd1; a2 = 2'd2; end
    endcase
    if (r[a0]) begin
      rr_pick = a0;
    end else if (r[a1]) begin
      rr_pick = a1;
    end else begin
      rr_pick = a2;
    end
  endfunction

  function automatic logic [2:0] idx2oh(input logic [1:0] idx);
    case (idx)
      2'd0:    idx2oh = 3'b001;
      2'd1:    idx2oh = 3'b010;
      2'd2:    idx2oh = 3'b100;
      default: idx2oh = 3'b000;
    endcase
  endfunction

  // Holder's request fields; the holder is always the last winner while in GRANT.
  always_comb begin
    hold_req_s   = 1'b0;
    hold_rd_s    = 1'b0;
    hold_wr_s    = 1'b0;
    hold_addr_s  = {ADDR_SIZE_BITS{1'b0}};
    hold_wdata_s = {DW{1'b0}};
    case (last_q)
      2'd0: begin
        hold_req_s   = req[0];
        hold_rd_s    = rd_en_in[0];
        hold_wr_s    = wr_en_in[0];
        hold_addr_s  = addr_in[0*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
        hold_wdata_s = wdata_in[0*DW +: DW];
      end
      2'd1: begin
        hold_req_s   = req[1];
        hold_rd_s    = rd_en_in[1];
        hold_wr_s    = wr_en_in[1];
        hold_addr_s  = addr_in[1*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
        hold_wdata_s = wdata_in[1*DW +: DW];
      end
      2'd2: begin
        hold_req_s   = req[2];
        hold_rd_s    = rd_en_in[2];
        hold_wr_s    = wr_en_in[2];
        hold_addr_s  = addr_in[2*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
        hold_wdata_s = wdata_in[2*DW +: DW];
      end
      default: begin
        hold_req_s   = 1'b0;
        hold_rd_s    = 1'b0;
        hold_wr_s    = 1'b0;
        hold_addr_s  = {ADDR_SIZE_BITS{1'b0}};
        hold_wdata_s = {DW{1'b0}};
      end
    endcase
  end

  // Arbitration state machine next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    pick_s  = rr_pick(req, last_q);
    case (state_q)
      ST_GRANT: begin
        if (hold_req_s) begin
          state_d = ST_GRANT;
        end else begin
          gnt_d   = 3'b000;
          state_d = ST_RELEASE;
        end
      end
      ST_IDLE, ST_RELEASE: begin
        if (req != 3'b000) begin
          gnt_d   = idx2oh(pick_s);
          last_d  = pick_s;
          state_d = ST_GRANT;
        end else begin
          gnt_d   = 3'b000;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers; last resets to 2 so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Memory port follows the holder with no added latency; a write wins over a read.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = {ADDR_SIZE_BITS{1'b0}};
    mem_write_data   = {DW{1'b0}};
    conflict_s       = 1'b0;
    if (state_q == ST_GRANT) begin
      mem_write_enable = hold_wr_s;
      mem_read_enable  = hold_rd_s & ~hold_wr_s;
      mem_address      = hold_addr_s;
      mem_write_data   = hold_wdata_s;
      conflict_s       = hold_rd_s & hold_wr_s;
    end else begin
      conflict_s       = 1'b0;
    end
  end

  assign protocol_err  = conflict_s & ~rst;
  assign gnt           = gnt_q;
  assign read_data_out = mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against
// a holder/last-winner reference model.
module tb_mem_arbiter;

  localparam int A  = 24;
  localparam int DW = 3 * 64 * 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req, rd_en_in, wr_en_in;
  logic [3*A-1:0]    addr_in;
  logic [3*DW-1:0]   wdata_in;
  logic [2:0]        gnt;
  logic [DW-1:0]     read_data_out;
  logic              mem_read_enable, mem_write_enable;
  logic [A-1:0]      mem_address;
  logic [DW-1:0]     mem_write_data;
  logic [DW-1:0]     mem_read_data;
  logic              protocol_err;

  int total = 0;
  int bad   = 0;
  int m_holder;
  int m_last;

  mem_arbiter #(.ADDR_SIZE_BITS(24), .WORD_SIZE_BYTES(3), .DATA_SIZE_WORDS(64)) dut (
    .clk(clk), .rst(rst), .req(req), .rd_en_in(rd_en_in), .wr_en_in(wr_en_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .read_data_out(read_data_out),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // One clock: the model applies the arbitration rules at the edge, then inputs may change.
  task automatic tick();
    bit found;
    @(posedge clk);
    found = 1'b0;
    if (rst) begin
      m_holder = -1;
      m_last   = 2;
    end else if (m_holder >= 0) begin
      if (!req[m_holder]) m_holder = -1;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (!found && req[(m_last + k) % 3]) begin
          m_holder = (m_last + k) % 3;
          m_last   = m_holder;
          found    = 1'b1;
        end
      end
    end
    #2;
  endtask

  task automatic clear_inputs();
    req = 3'b000; rd_en_in = 3'b000; wr_en_in = 3'b000;
    addr_in = '0; wdata_in = '0; mem_read_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    total++; if ({mem_read_enable, mem_write_enable, protocol_err} !== 3'b000) begin bad++;
      $display("FAIL reset_en got=%b exp=000", {mem_read_enable, mem_write_enable, protocol_err}); end
    total++; if (mem_address !== 24'h000000) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    rst = 1'b1; req = 3'b111;
    tick(); #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_held_gnt got=%b exp=000", gnt); end
    tick(); #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_held_gnt2 got=%b exp=000", gnt); end
    rst = 1'b0; req = 3'b000;
  endtask

  task automatic test_first_grant();
    logic [DW-1:0] rdat;
    do_reset();
    req = 3'b010;
    tick(); #1;
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL first_gnt got=%b exp=010", gnt); end
    rd_en_in = 3'b010;
    addr_in[0*A +: A] = 24'hABCDEF;
    addr_in[1*A +: A] = 24'h000100;
    for (int i = 0; i < DW/32; i++) rdat[i*32 +: 32] = $urandom();
    mem_read_data = rdat;
    #1;
    total++; if (mem_read_enable !== 1'b1) begin bad++; $display("FAIL first_rd got=%b exp=1", mem_read_enable); end
    total++; if (mem_address !== 24'h000100) begin bad++; $display("FAIL first_addr got=%h exp=000100", mem_address); end
    total++; if (read_data_out !== rdat) begin bad++;
      $display("FAIL first_rdata got=%h exp=%h", read_data_out[127:0], rdat[127:0]); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    logic [2:0] exp;
    do_reset();
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      exp = 3'b001 << order[r];
      for (int c = 0; c < 4; c++) begin
        tick(); #1;
        total++; if (gnt !== exp) begin bad++; $display("FAIL rr_hold r=%0d c=%0d got=%b exp=%b", r, c, gnt, exp); end
      end
      req[order[r]] = 1'b0;
      tick(); #1;
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rr_dead r=%0d got=%b exp=000", r, gnt); end
      req = (r == 3) ? 3'b000 : 3'b111;
    end
    tick();
  endtask

  task automatic test_nonholder_blocked();
    logic [DW-1:0] wd2;
    do_reset();
    req = 3'b010;
    tick();
    for (int i = 0; i < DW/32; i++) wd2[i*32 +: 32] = $urandom();
    req = 3'b110; wr_en_in = 3'b100;
    addr_in[2*A +: A] = 24'h00BEEF;
    wdata_in[2*DW +: DW] = wd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (mem_write_enable !== 1'b0 || gnt !== 3'b010) begin bad++;
        $display("FAIL block_wr c=%0d got we=%b gnt=%b exp we=0 gnt=010", c, mem_write_enable, gnt); end
      tick();
    end
    req = 3'b100;
    tick(); #1;
    total++; if (mem_write_enable !== 1'b0 || gnt !== 3'b000) begin bad++;
      $display("FAIL block_dead got we=%b gnt=%b exp we=0 gnt=000", mem_write_enable, gnt); end
    tick(); #1;
    total++; if (gnt !== 3'b100 || mem_write_enable !== 1'b1 || mem_address !== 24'h00BEEF) begin bad++;
      $display("FAIL block_p2 got gnt=%b we=%b addr=%h exp gnt=100 we=1 addr=00beef", gnt, mem_write_enable, mem_address); end
    total++; if (mem_write_data !== wd2) begin bad++;
      $display("FAIL block_wdata got=%h exp=%h", mem_write_data[127:0], wd2[127:0]); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_rdwr_conflict();
    do_reset();
    req = 3'b001;
    tick();
    rd_en_in = 3'b001; wr_en_in = 3'b001;
    wdata_in[0*DW +: DW] = {DW{1'b1}};
    #1;
    total++; if ({mem_write_enable, mem_read_enable, protocol_err} !== 3'b101) begin bad++;
      $display("FAIL conflict got we,re,err=%b exp=101", {mem_write_enable, mem_read_enable, protocol_err}); end
    total++; if (mem_write_data !== {DW{1'b1}}) begin bad++;
      $display("FAIL conflict_wdata got=%h exp=all ones", mem_write_data[127:0]); end
    tick();
    rd_en_in = 3'b000;
    #1;
    total++; if ({mem_write_enable, protocol_err} !== 2'b10) begin bad++;
      $display("FAIL conflict_end got we,err=%b exp=10", {mem_write_enable, protocol_err}); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 3'b001;
    tick();
    wr_en_in = 3'b001;
    #1;
    total++; if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", mem_write_enable); end
    rst = 1'b1;
    tick(); #1;
    total++; if (gnt !== 3'b000 || mem_write_enable !== 1'b0) begin bad++;
      $display("FAIL midrst got gnt=%b we=%b exp gnt=000 we=0", gnt, mem_write_enable); end
    rst = 1'b0; wr_en_in = 3'b000; req = 3'b101;
    tick(); #1;
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL midrst_regrant got=%b exp=001", gnt); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_lone_regrant();
    do_reset();
    req = 3'b100;
    tick(); #1;
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL lone_first got=%b exp=100", gnt); end
    req = 3'b000;
    tick(); #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL lone_gap got=%b exp=000", gnt); end
    req = 3'b100;
    tick(); #1;
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL lone_regrant got=%b exp=100", gnt); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [2:0]    eg;
    logic          erd, ewr, eerr;
    logic [A-1:0]  eaddr;
    logic [DW-1:0] ewd;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      rd_en_in = 3'($urandom());
      wr_en_in = 3'($urandom());
      addr_in  = {24'($urandom()), 24'($urandom()), 24'($urandom())};
      for (int i = 0; i < 3*DW/32; i++) wdata_in[i*32 +: 32] = $urandom();
      for (int i = 0; i < DW/32; i++) mem_read_data[i*32 +: 32] = $urandom();
      rst = ($urandom_range(0, 49) == 0);
      #1;
      eg = 3'b000; erd = 1'b0; ewr = 1'b0; eerr = 1'b0; eaddr = '0; ewd = '0;
      if (m_holder >= 0) begin
        eg    = 3'b001 << m_holder;
        ewr   = wr_en_in[m_holder];
        erd   = rd_en_in[m_holder] & ~wr_en_in[m_holder];
        eerr  = rd_en_in[m_holder] & wr_en_in[m_holder] & ~rst;
        eaddr = addr_in[m_holder*A +: A];
        ewd   = wdata_in[m_holder*DW +: DW];
      end
      total++; if (gnt !== eg) begin bad++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
      total++; if ({mem_read_enable, mem_write_enable, protocol_err} !== {erd, ewr, eerr}) begin bad++;
        $display("FAIL rand_en cyc=%0d got re,we,err=%b exp=%b", cyc,
                 {mem_read_enable, mem_write_enable, protocol_err}, {erd, ewr, eerr}); end
      total++; if (mem_address !== eaddr) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, mem_address, eaddr); end
      total++; if (mem_write_data !== ewd) begin bad++;
        $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, mem_write_data[127:0], ewd[127:0]); end
      total++; if (read_data_out !== mem_read_data) begin bad++;
        $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, read_data_out[127:0], mem_read_data[127:0]); end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    m_holder = -1;
    m_last   = 2;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_nonholder_blocked();
    test_rdwr_conflict();
    test_reset_mid_grant();
    test_lone_regrant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
